// File: rtl/crc_weight_packer_pkg.sv
// crc_weight_packer_pkg: shared widths, polynomial, FSM states and slot-offset helper
package crc_weight_packer_pkg;
  localparam int NB = 8;
  localparam int WW = 32;
  localparam int CL = 8;
  localparam logic [CL-1:0] POLY_DEF = 8'h07;
  localparam int CW = WW + CL;
  typedef enum logic {FILL, FULL} state_e;
  function automatic int slot_msb(input int k, input int cw = CW);
    return cw * (k + 1) - 1;
  endfunction
endpackage

// File: rtl/crc_weight_packer_if.sv
// crc_weight_packer_if: weight input, packed beat output and status of the packer
interface crc_weight_packer_if import crc_weight_packer_pkg::*; #(
  parameter int N  = NB,
  parameter int n  = WW,
  parameter int cl = CL
);
  logic                    clr;
  logic [n-1:0]            w_in;
  logic                    w_valid;
  logic                    w_ready;
  logic                    inj_err;
  logic [N*(n+cl)-1:0]     wcrc;
  logic                    wcrc_valid;
  logic                    wcrc_ready;
  logic [15:0]             beat_cnt;
  modport master(output clr, w_in, w_valid, inj_err, wcrc_ready,
                 input w_ready, wcrc, wcrc_valid, beat_cnt);
  modport slave(input clr, w_in, w_valid, inj_err, wcrc_ready,
                output w_ready, wcrc, wcrc_valid, beat_cnt);
endinterface

// File: rtl/crc_weight_packer_crc_gen.sv
// crc_gen: combinational MSB-first non-reflected CRC, init 0, no final XOR
module crc_gen import crc_weight_packer_pkg::*; #(
  parameter int n  = WW,
  parameter int cl = CL,
  parameter logic [cl-1:0] POLY = POLY_DEF
) (
  input  logic [n-1:0]  data_i,
  output logic [cl-1:0] crc_o
);
  always_comb begin
    crc_o = '0;
    for (int i = n - 1; i >= 0; i--)
      crc_o = {crc_o[cl-2:0], 1'b0} ^ ((crc_o[cl-1] ^ data_i[i]) ? POLY : '0);
  end
endmodule

// File: rtl/crc_weight_packer.sv
// crc_weight_packer: packs N {weight, crc} codewords into one beat with a valid/ready handshake
module crc_weight_packer import crc_weight_packer_pkg::*; #(
  parameter int N  = NB,
  parameter int n  = WW,
  parameter int cl = CL,
  parameter logic [cl-1:0] POLY = POLY_DEF
) (
  input logic                clk,
  input logic                reset,
  crc_weight_packer_if.slave bus
);
  localparam int W     = n + cl;
  localparam int CNT_W = N > 1 ? $clog2(N) : 1;
  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N*W-1:0]      wcrc_q, wcrc_d;
  logic [15:0]         beat_q, beat_d;
  logic [cl-1:0]       crc;
  logic                accept, last;
  crc_gen #(.n(n), .cl(cl), .POLY(POLY)) u_crc (.data_i(bus.w_in), .crc_o(crc));
  assign accept = state_q == FILL && bus.w_valid && !bus.clr;
  assign last   = cnt_q == CNT_W'(N - 1);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wcrc_d  = wcrc_q;
    beat_d  = beat_q;
    if (state_q == FILL && bus.clr) cnt_d = '0;
    else if (accept) begin
      for (int k = 0; k < N; k++)
        if (cnt_q == CNT_W'(k)) wcrc_d[slot_msb(k, W) -: W] = {bus.w_in, crc ^ {{(cl-1){1'b0}}, bus.inj_err}};
      cnt_d   = last ? '0 : cnt_q + 1'b1;
      state_d = last ? FULL : FILL;
    end
    if (state_q == FULL && bus.wcrc_ready) begin
      state_d = FILL;
      beat_d  = beat_q + 16'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      cnt_q   <= '0;
      wcrc_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wcrc_q  <= wcrc_d;
      beat_q  <= beat_d;
    end
  end
  assign bus.w_ready    = state_q == FILL && !reset;
  assign bus.wcrc_valid = state_q == FULL && !reset;
  assign bus.wcrc       = wcrc_q;
  assign bus.beat_cnt   = beat_q;
  a_valid_hold: assert property (@(posedge clk) disable iff (reset)
    bus.wcrc_valid && !bus.wcrc_ready |=> bus.wcrc_valid);
  a_data_stable: assert property (@(posedge clk) disable iff (reset)
    bus.wcrc_valid && !bus.wcrc_ready |=> $stable(bus.wcrc));
  a_no_full_accept: assert property (@(posedge clk) disable iff (reset)
    bus.w_valid && bus.w_ready |-> state_q == FILL);
endmodule

// File: doc/crc_weight_packer.md
Name: crc_weight_packer

Overview:
- Transmit side of the protected weight path: accepts raw n-bit weights one per handshake and computes a cl-bit CRC for each.
- Packs N (weight, CRC) codewords into one wide bus, in exactly the layout and CRC definition the stage-2 neuron's per-word CRC checker expects.
- Presents the bus with a valid/ready handshake to the weight memory/loader feeding s2neuron.
- Includes an error-injection control so benches can force checker faults and exercise the downstream fault flag and MAC freeze.

Parameters:
- N, 8, codewords per packed beat (neurons per layer slice).
- n, 32, weight width in bits.
- cl, 8, CRC width in bits.
- POLY, 8'h07, CRC generator polynomial without the implicit x^cl term (cl bits wide).

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- clr  input  1  synchronous flush of a partially filled beat.
- w_in  input  n  raw weight.
- w_valid  input  1  w_in valid.
- w_ready  output  1  packer can accept a weight.
- inj_err  input  1  sampled with each accepted weight; corrupts that word's CRC.
- wcrc  output  N*(n+cl)  packed codewords.
- wcrc_valid  output  1  wcrc holds a complete beat.
- wcrc_ready  input  1  consumer takes the beat.
- beat_cnt  output  16  beats delivered since reset; wraps at 0xFFFF to 0.

Behaviour:
- One clock (clk); reset is synchronous and active-high. All state updates on the rising edge of clk.
- CRC definition (shared with checker):
  - Non-reflected, MSB-first, init 0, no final XOR.
  - crc = (w * x^cl) mod (x^cl + POLY) over GF(2).
  - Codeword = {w, crc}: weight in the upper n bits, CRC in the low cl bits.
- Slot mapping: the k-th accepted weight of a beat (k = 0..N-1) is written to wcrc[(n+cl)*(k+1)-1 -: (n+cl)]. Slot 1 occupies the LSBs.
- Error injection: if inj_err = 1 when a weight is accepted, that slot's CRC bit 0 is inverted. Other slots are unaffected.
- FSM, two states:
  - FILL: w_ready = 1, wcrc_valid = 0.
    - Accept occurs when w_valid & w_ready: write the slot, then cnt++.
    - The accept with cnt = N-1 moves to FULL on the same edge and resets cnt to 0.
    - wcrc_valid rises the cycle after the N-th accept (latency 1 from last accept).
  - FULL: w_ready = 0, wcrc_valid = 1, wcrc held stable.
    - When wcrc_ready = 1: return to FILL and increment beat_cnt.
    - The next weight can be accepted the cycle after the transfer (no back-to-back overlap).
- clr:
  - In FILL: cnt goes to 0 and slot contents are discarded; an accept in the same cycle is dropped.
  - In FULL: ignored, so a complete beat is never lost.
- Reset outputs:
  - wcrc = 0, wcrc_valid = 0, w_ready = 0 during reset, then 1 from the first cycle after reset deasserts.
  - beat_cnt = 0, cnt = 0, state = FILL.
- Reset mid-beat discards partial contents. Reset while in FULL drops the beat; beat_cnt is not incremented.
- Slots not yet written in the current beat keep stale data but are never presented, because valid stays low until all N are written.
- Protocol checks, enforced by assertions:
  - wcrc_valid, once high, stays high until wcrc_ready.
  - wcrc is stable while valid and not ready.
  - No accept occurs in FULL.

Decomposition:
- Shared package (used by this block and the checker):
  - CRC width and polynomial constants.
  - Codeword width constant n+cl.
  - The slot-offset function (n+cl)*(k+1)-1.
- Sub-module crc_gen #(n, cl, POLY): combinational MSB-first CRC over n bits, implemented as an unrolled LFSR loop.
  - Must be bit-identical to the checker's computation.
  - The checker should be refactored to instantiate it.
- FSM, counters, slot registers and injection logic stay in crc_weight_packer.

Test Plan (all at defaults):
- Load 0x00000000, 0x00000001, 0x00000002, then five further zeros; assert ready -> wcrc_valid one cycle after the 8th accept.
  - Slot1 = 40'h00_0000_0000, slot2 = 40'h00_0000_0107, slot3 = 40'h00_0000_020E.
  - beat_cnt = 1 after the transfer.
- Backpressure: hold wcrc_ready = 0 for 10 cycles after a beat completes -> wcrc_valid stays 1, wcrc unchanged, w_ready = 0, offered w_valid pulses are not accepted.
- inj_err = 1 on the 4th weight (0x00000001) -> slot4 = 40'h00_0000_0106, all other slots correct. Feeding s2neuron with this beat raises cfflag.
- clr after 5 accepts, then 8 new weights 0x00000001 -> all eight slots = 40'h00_0000_0107, with no leftover data from before the clr.
- reset asserted in FULL and mid-FILL -> wcrc_valid = 0 and wcrc = 0 on the next cycle, beat_cnt unchanged from 0.
  - A subsequent 8 accepts produce a clean beat.
- Random weights over 1000 beats -> every slot passes the crc_checker reference model; beat_cnt = 1000.
